// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants and types: data/PC widths, the NOP encoding,
// fetch control states and the fetch queue entry layout.
package cpu_pkg;

   localparam int XLEN = 32;
   localparam int PC_W = 32;
   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

   typedef enum logic {
      FETCH_IDLE,
      FETCH_RUN
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] data;
      logic [PC_W-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction queue of {data, pc} entries with synchronous clear.
// Storage is unreset; only pointers and the occupancy count carry reset state.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int PW = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  fetch_entry_t  pushEntry_i,
   input  logic          pop_i,
   input  logic          clear_i,
   output fetch_entry_t  headEntry_o,
   output logic [CW-1:0] count_o
);

   fetch_entry_t  mem_q [DEPTH];
   logic [PW-1:0] rdPtr_q, wrPtr_q;
   logic [CW-1:0] count_q;
   logic          doPush, doPop;

   // A push into a full queue is accepted only when a pop frees the head slot.
   assign doPop  = pop_i && (count_q != '0);
   assign doPush = push_i && ((count_q != CW'(DEPTH)) || doPop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else if (clear_i) begin
         rdPtr_q <= '0;
         wrPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
         if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
         count_q <= count_q + CW'(doPush) - CW'(doPop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (doPush && !clear_i) mem_q[wrPtr_q] <= pushEntry_i;
   end

   assign headEntry_o = mem_q[rdPtr_q];
   assign count_o     = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues word-addressed imem requests, queues returned
// instructions with their PCs for decode, and flushes on redirect.
module inst_fetch #(
   parameter int                        DEPTH    = 4,
   parameter logic [cpu_pkg::XLEN-1:0]  NOP_INST = cpu_pkg::NOP_INST
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_start,
   input  logic                        i_stall,
   input  logic                        i_redirect,
   input  logic [cpu_pkg::PC_W-1:0]    i_redirect_pc,
   output logic                        o_imem_req,
   output logic [cpu_pkg::PC_W-1:0]    o_imem_addr,
   input  logic                        i_imem_ack,
   input  logic                        i_imem_rvalid,
   input  logic [cpu_pkg::XLEN-1:0]    i_imem_rdata,
   output logic                        o_inst_valid,
   output logic [cpu_pkg::XLEN-1:0]    o_inst_data,
   output logic [cpu_pkg::PC_W-1:0]    o_inst_pc
);
   import cpu_pkg::*;

   localparam int CW = $clog2(DEPTH + 1);

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] fetchPc_q, fetchPc_d;
   logic [PC_W-1:0] respPc_q, respPc_d;
   logic [CW-1:0]   inflight_q, inflight_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic [CW-1:0]   count;
   logic            running, flush, xfer, rspAccept, push, pop;
   fetch_entry_t    pushEntry, headEntry;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= FETCH_IDLE;
         fetchPc_q  <= '0;
         respPc_q   <= '0;
         inflight_q <= '0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         fetchPc_q  <= fetchPc_d;
         respPc_q   <= respPc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   // Responses with nothing in flight are stray (e.g. after reset) and ignored.
   always_comb begin
      state_d    = state_q;
      fetchPc_d  = fetchPc_q;
      respPc_d   = respPc_q;
      drop_d     = drop_q;
      push       = 1'b0;
      pushEntry  = '{data: i_imem_rdata, pc: respPc_q};
      running    = (state_q == FETCH_RUN);
      flush      = running && i_redirect;
      o_imem_req = running && !i_redirect &&
                   (({1'b0, count} + {1'b0, inflight_q}) < (CW + 1)'(DEPTH));
      xfer       = o_imem_req && i_imem_ack;
      rspAccept  = i_imem_rvalid && (inflight_q != '0);
      inflight_d = inflight_q + CW'(xfer) - CW'(rspAccept);

      if (!running && i_start) state_d = FETCH_RUN;

      if (flush) begin
         fetchPc_d = i_redirect_pc;
         respPc_d  = i_redirect_pc;
         drop_d    = inflight_q - CW'(rspAccept);
      end else begin
         if (xfer) fetchPc_d = fetchPc_q + 1'b1;
         if (rspAccept) begin
            if (drop_q != '0) begin
               drop_d = drop_q - 1'b1;
            end else begin
               push     = 1'b1;
               respPc_d = respPc_q + 1'b1;
            end
         end
      end
   end

   assign pop          = o_inst_valid && !i_stall;
   assign o_imem_addr  = fetchPc_q;
   assign o_inst_valid = (count != '0);
   assign o_inst_data  = o_inst_valid ? headEntry.data : NOP_INST;
   assign o_inst_pc    = o_inst_valid ? headEntry.pc : '0;

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i       (i_clk),
      .rst_ni      (i_rst_n),
      .push_i      (push),
      .pushEntry_i (pushEntry),
      .pop_i       (pop),
      .clear_i     (flush),
      .headEntry_o (headEntry),
      .count_o     (count)
   );

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus randomized memory timing, checked
// against a stream-level model (expected next request address and next delivered PC).
module tb_inst_fetch;
   import cpu_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        i_rst_n;
   logic        i_start, i_stall, i_redirect;
   logic [31:0] i_redirect_pc;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ack, i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        o_inst_valid;
   logic [31:0] o_inst_data, o_inst_pc;

   always #5 clk = ~clk;

   inst_fetch #(
      .DEPTH    (DEPTH),
      .NOP_INST (32'h0000_0013)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (i_rst_n),
      .i_start       (i_start),
      .i_stall       (i_stall),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_ack    (i_imem_ack),
      .i_imem_rvalid (i_imem_rvalid),
      .i_imem_rdata  (i_imem_rdata),
      .o_inst_valid  (o_inst_valid),
      .o_inst_data   (o_inst_data),
      .o_inst_pc     (o_inst_pc)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } memRsp_t;

   memRsp_t     memQ[$];
   int          cyc = 0;
   int          lastDue = -1;
   int          memLat = 1;
   int          memJitter = 0;
   int          checks = 0;
   int          errors = 0;
   int          consumed = 0;
   int          firstValid = -1;
   logic [31:0] expPc = '0;
   logic [31:0] expReqAddr = '0;
   bit          runExp = 1'b0;
   bit          mustBeInvalid = 1'b0;
   bit          lastValid = 1'b0;

   function automatic logic [31:0] memFn(input logic [31:0] a);
      return 32'h1000 + a;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs and memory response at negedge, then check the settled outputs.
   task automatic applyStimulus(input bit start, input bit stall, input bit ack,
                                input bit redir, input logic [31:0] target);
      int due;
      @(negedge clk);
      i_start       = start;
      i_stall       = stall;
      i_imem_ack    = ack;
      i_redirect    = redir;
      i_redirect_pc = target;
      if (memQ.size() > 0 && memQ[0].due <= cyc) begin
         i_imem_rvalid = 1'b1;
         i_imem_rdata  = memFn(memQ[0].addr);
         void'(memQ.pop_front());
      end else begin
         i_imem_rvalid = 1'b0;
         i_imem_rdata  = $urandom;
      end
      #1;
      if (!runExp || redir) checkOutput("req_blocked", 32'(o_imem_req), 32'd0);
      if (o_imem_req) begin
         checkOutput("req_addr", o_imem_addr, expReqAddr);
         if (ack) begin
            due = cyc + memLat + int'($urandom_range(0, memJitter));
            if (due <= lastDue) due = lastDue + 1;
            lastDue = due;
            memQ.push_back('{addr: o_imem_addr, due: due});
            expReqAddr = expReqAddr + 1;
         end
      end
      checkOutput("outstanding_bound", 32'(memQ.size() <= DEPTH), 32'd1);
      if (mustBeInvalid || !runExp) checkOutput("valid_after_flush", 32'(o_inst_valid), 32'd0);
      mustBeInvalid = 1'b0;
      lastValid = o_inst_valid;
      if (o_inst_valid) begin
         if (firstValid < 0) firstValid = cyc;
         checkOutput("inst_pc", o_inst_pc, expPc);
         checkOutput("inst_data", o_inst_data, memFn(expPc));
         if (!stall) begin
            consumed++;
            expPc = expPc + 1;
         end
      end
      if (runExp && redir) begin
         expPc         = target;
         expReqAddr    = target;
         mustBeInvalid = 1'b1;
      end
      if (start) runExp = 1'b1;
      cyc++;
   endtask

   task automatic waitValid(input int budget, input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
         seen = lastValid;
      end
      checkOutput(tag, 32'(seen), 32'd1);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_req"},   32'(o_imem_req),   32'd0);
      checkOutput({tag, "_addr"},  o_imem_addr,       32'd0);
      checkOutput({tag, "_valid"}, 32'(o_inst_valid), 32'd0);
      checkOutput({tag, "_data"},  o_inst_data,       32'h0000_0013);
      checkOutput({tag, "_pc"},    o_inst_pc,         32'd0);
   endtask

   initial begin
      int startCyc, base, idleBudget;
      i_rst_n       = 1'b0;
      i_start       = 1'b0;
      i_stall       = 1'b0;
      i_redirect    = 1'b0;
      i_redirect_pc = '0;
      i_imem_ack    = 1'b0;
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = '0;
      repeat (2) @(negedge clk);
      #1;
      checkResetOutputs("reset");
      i_rst_n = 1'b1;

      $display("[TB] latency and throughput with 1-cycle memory");
      memLat   = 1;
      startCyc = cyc;
      base     = consumed;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("first_valid_cycle", 32'(firstValid - startCyc), 32'd3);
      checkOutput("throughput", 32'(consumed - base), 32'd10);

      $display("[TB] decode stall for 5 cycles");
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

      $display("[TB] redirect with responses in flight");
      memLat = 3;
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h40);
      waitValid(20, "wait_after_redirect_40");
      checkOutput("redirect_40_pc", o_inst_pc, 32'h40);
      checkOutput("redirect_40_data", o_inst_data, 32'h1040);

      $display("[TB] redirect coinciding with rvalid and push+pop");
      memLat = 1;
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
      waitValid(10, "wait_after_redirect_80");
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

      $display("[TB] ack withheld 3 cycles, 4-cycle read latency");
      memLat = 4;
      for (int i = 0; i < 32; i++) applyStimulus(1'b0, 1'b0, (i % 4) == 3, 1'b0, 32'd0);

      $display("[TB] reset while queue full");
      memLat = 1;
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      @(negedge clk);
      #2;
      i_rst_n = 1'b0;
      #1;
      checkResetOutputs("midreset");
      runExp        = 1'b0;
      mustBeInvalid = 1'b0;
      expPc         = '0;
      expReqAddr    = '0;
      #1;
      i_rst_n = 1'b1;
      idleBudget = 0;
      while (memQ.size() > 0 && idleBudget < 20) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
         idleBudget++;
      end
      checkOutput("late_rsp_drained", 32'(memQ.size()), 32'd0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);

      $display("[TB] randomized traffic");
      memJitter = 3;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
      for (int i = 0; i < 400; i++) begin
         logic [31:0] tgt;
         bit          rd;
         rd  = ($urandom_range(0, 39) == 0);
         tgt = (i > 300 && $urandom_range(0, 1) == 0) ? 32'hFFFF_FFFD : 32'($urandom_range(0, 4095));
         applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 2) != 0, rd, tgt);
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE);
      memJitter = 0;
      base = consumed;
      for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput("drain_progress", 32'(consumed - base >= 20), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage sitting directly upstream of the decode stage (`inst_dec` input register). It issues word-addressed requests to instruction memory and buffers returned instructions, with their PCs, in an in-order queue. It presents one instruction per cycle to decode, honours decode back-pressure, and performs a full flush on a branch/jump redirect, discarding any responses still in flight.

## Interface
- `DEPTH`, 4: queue entries and maximum of (queued + outstanding) fetches; power of two, ≥2.
- `NOP_INST`, 32'h0000_0013: instruction driven when no valid instruction is available (`addi x0,x0,0`).
- `i_clk` in 1: the single clock; all state on rising edge.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_start` in 1: leaves IDLE and begins fetching at PC 0.
- `i_stall` in 1: decode cannot accept this cycle.
- `i_redirect` in 1: flush and restart fetch at `i_redirect_pc`.
- `i_redirect_pc` in 32: word address of the new fetch target.
- `o_imem_req` out 1: fetch request valid.
- `o_imem_addr` out 32: word address of the request.
- `i_imem_ack` in 1: memory accepts the request this cycle (transfer = req & ack).
- `i_imem_rvalid` in 1: read data valid; responses return in request order, ≥1 cycle after ack.
- `i_imem_rdata` in 32: instruction word.
- `o_inst_valid` out 1: `o_inst_data`/`o_inst_pc` hold a real instruction.
- `o_inst_data` out 32: instruction to decode; `NOP_INST` when not valid.
- `o_inst_pc` out 32: word PC of `o_inst_data`; 0 when not valid.

## Operation
- States: IDLE (after reset) → RUN on `i_start`. RUN holds until reset; `i_start` is ignored in RUN.
- Registers: `fetch_pc` (next request address), `resp_pc` (PC of next accepted response), `inflight` and `drop` counters (width clog2(DEPTH+1)), and the queue.
- Request: `o_imem_req` = RUN & !`i_redirect` & (count + inflight < DEPTH), using registered count only. `o_imem_addr` = `fetch_pc`. The request is combinational. It may be withdrawn or re-addressed before ack, and memory tolerates this.
- On req&ack: `fetch_pc` +1 (32-bit wrap), `inflight` +1.
- On `i_imem_rvalid`: `inflight` −1. If `drop` > 0, `drop` −1 and the data is discarded. Otherwise push {rdata, `resp_pc`} and increment `resp_pc`.
- Pop: when `o_inst_valid` & !`i_stall`. Push and pop can occur in the same cycle at any count.
- Redirect (highest priority, RUN only):
  - Queue is emptied.
  - `fetch_pc` and `resp_pc` are loaded with `i_redirect_pc`.
  - `drop` is set to `inflight` minus the response arriving this cycle. A response arriving in the redirect cycle is always discarded.
  - No request is issued in the redirect cycle.
- Overflow cannot occur by construction. An rvalid with `inflight` = 0 is a protocol error: it is ignored and the counters saturate at 0.

## Timing
- Reset values: `o_imem_req`=0, `o_imem_addr`=0, `o_inst_valid`=0, `o_inst_data`=`NOP_INST`, `o_inst_pc`=0. All counters 0, state IDLE.
- `i_start` high in cycle 0 → first request in cycle 1.
- Latency: with a 1-cycle memory (ack in cycle 1, rvalid in cycle 2), `o_inst_valid` is asserted in cycle 3. Push is registered and there is no bypass.
- With DEPTH=4 and a 1-cycle memory, throughput is sustained at one instruction per cycle.
- Redirect in cycle t: `o_inst_valid`=0 in t+1; new-target request in t+1.
- Reset asserted mid-operation: all state and outputs return to reset values immediately (asynchronous). Late memory responses arriving after reset release are ignored (inflight=0).

## Structure
- Shared package `cpu_pkg` holds `NOP_INST`, `XLEN`=32, and the PC width.
- One sub-module, `fetch_fifo`: a synchronous FIFO of {data[31:0], pc[31:0]} with push, pop, clear, count, and the same asynchronous active-low reset.

## Test plan
- Reset, `i_start`, 1-cycle memory returning rdata = 0x1000+addr → `o_inst_valid` in cycle 3, then PCs 0,1,2,… with data 0x1000,0x1001,… one per cycle.
- `i_stall` held 5 cycles in steady state → at most 4 requests outstanding or queued, no loss. Release resumes at the next PC in order.
- Redirect to 0x40 with 2 responses in flight → both discarded, next valid output is PC 0x40, data 0x1040.
- Redirect in the same cycle as rvalid and as a push+pop → queue empty next cycle, drop count correct, first output PC = target.
- Memory with ack withheld for 3 cycles and 4-cycle read latency → correct in-order PC/data stream and req never issued in IDLE.
- Reset asserted while the queue is full → outputs `NOP_INST`/0/invalid immediately. Fetch does not restart until `i_start` is asserted.
